slv_guard_rst_ctrl: RTL and testbench
=====================================

# slv_guard_rst_ctrl

Reset sequencer directly downstream of the subordinate guard's reset-request output. It converts the guard's level reset request into a timed, active-low reset pulse for the guarded subordinate, waits a settle interval, then returns a reset-complete status that clears the guard's request. It also reports sequence activity and counts completed resets for software visibility.

## Interface
- `PulseCycles`, default 16: number of cycles `sub_rst_no` is held low per sequence; must be ≥1 (elaboration assertion).
- `SettleCycles`, default 8: cycles between reset release and status assertion; 0 means the SETTLE state is skipped.
- `RstCntWidth`, default 8: width of the completed-reset counter.
- `TmrWidth`, derived, do not override: `$clog2(max(PulseCycles, SettleCycles) + 1)`.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `rst_en_i`, in, 1: sequencer enable (guard enable); only sampled in IDLE.
- `rst_req_i`, in, 1: level reset request from the guard.
- `sub_rst_no`, out, 1: active-low reset to the guarded subordinate; registered.
- `rst_stat_o`, out, 1: reset-complete status to the guard's reset-clear input; registered.
- `busy_o`, out, 1: high in any state other than IDLE.
- `done_o`, out, 1: one-cycle pulse when a sequence retires.
- `rst_cnt_o`, out, `RstCntWidth`: saturating count of completed sequences.

## Operation
- States: IDLE, ASSERT, SETTLE, DONE. The state register is in a 2-bit encoding. `TmrWidth` down-counter `tmr_q`.
- **IDLE:** `sub_rst_no`=1, `rst_stat_o`=0.
  - If `rst_req_i` && `rst_en_i`, go to ASSERT and load `tmr_q` = `PulseCycles-1`.
- **ASSERT:** `sub_rst_no`=0.
  - While `tmr_q`≠0, decrement.
  - At `tmr_q`==0: if `SettleCycles`>0, go to SETTLE and load `SettleCycles-1`; else go to DONE.
- **SETTLE:** `sub_rst_no`=1.
  - Decrement `tmr_q`; at 0 go to DONE.
- **DONE:** `rst_stat_o`=1, `sub_rst_no`=1.
  - Stay in DONE while `rst_req_i`=1.
  - On `rst_req_i`=0, go to IDLE. That cycle: `done_o`=1 and `rst_cnt_o` increments.
- Counter arithmetic: `rst_cnt_o` increments by 1 and saturates at all-ones; it never wraps.
- Sequence is non-abortable:
  - `rst_en_i` deasserting outside IDLE has no effect.
  - `rst_req_i` dropping during ASSERT/SETTLE does not shorten the pulse. DONE is still entered, then exits after one cycle because the request is already low.
- Re-request: if `rst_req_i` is high again in the IDLE cycle after DONE, a new sequence starts. There is no built-in holdoff; the guard deasserts its request on `rst_stat_o`.
- Async reset mid-sequence: immediately return to IDLE, timer 0, all outputs at their reset values. `rst_cnt_o` clears. The subordinate's own system reset is handled by the SoC reset tree, not this block.

## Timing
- Reset values:
  - `sub_rst_no`=1, `rst_stat_o`=0, `busy_o`=0, `done_o`=0, `rst_cnt_o`=0.
  - State IDLE, `tmr_q`=0.
- Let the request be sampled at edge t.
- ASSERT covers cycles t+1 … t+P: `sub_rst_no` low exactly P cycles, where P = `PulseCycles`.
- SETTLE covers cycles t+P+1 … t+P+S, where S = `SettleCycles`.
- DONE is entered at t+P+S+1; `rst_stat_o` rises there.
- Minimum request-to-status latency is P+S+1 cycles.
- If `rst_req_i` is sampled low at edge u in DONE:
  - At u+1, `rst_stat_o`=0, `done_o`=1, `busy_o`=0, and `rst_cnt_o` is already incremented.
  - DONE therefore lasts at least 1 cycle.
- `busy_o` rises at t+1 and falls the cycle `done_o` pulses.
- All outputs are flop outputs; there is no combinational path from inputs to outputs.

## Test plan
- **Basic sequence:** P=16, S=8.
  - Stimulus: raise `rst_req_i` at cycle 10; drop it 1 cycle after `rst_stat_o` rises.
  - Required: `sub_rst_no` low cycles 11–26; `rst_stat_o` high from cycle 35; `done_o` at 37; `rst_cnt_o`=1.
- **Disabled:** `rst_en_i`=0 with `rst_req_i`=1 held 100 cycles.
  - Required: state IDLE, `sub_rst_no`=1, `busy_o`=0.
  - Then set `rst_en_i`=1: ASSERT begins on the next cycle.
- **Early request drop:** request pulses for 1 cycle only.
  - Required: a full 16-cycle low pulse, then `rst_stat_o` high for exactly 1 cycle, then `done_o`.
- **SettleCycles=0:**
  - Required: `rst_stat_o` rises at t+P+1 = t+17.
- **Saturation:** `RstCntWidth`=2; run 5 sequences.
  - Required: `rst_cnt_o` reads 1, 2, 3, 3, 3.
- **Mid-sequence reset:** assert `rst_ni` low at cycle t+5 of ASSERT.
  - Required: immediately `sub_rst_no`=1, `busy_o`=0, `rst_cnt_o`=0.
  - After release with `rst_req_i` still high, a fresh full P-cycle pulse follows.

Source files
------------

// File: rtl/slv_guard_rst_ctrl.sv
// Reset sequencer for the subordinate guard: turns a level reset request into a
// timed active-low reset pulse, waits a settle interval, then reports completion.
module slv_guard_rst_ctrl #(
    parameter int PulseCycles  = 16,
    parameter int SettleCycles = 8,
    parameter int RstCntWidth  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rst_en_i,
    input  logic                   rst_req_i,
    output logic                   sub_rst_no,
    output logic                   rst_stat_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [RstCntWidth-1:0] rst_cnt_o
);

    localparam int MaxCycles = (PulseCycles > SettleCycles) ? PulseCycles : SettleCycles;
    localparam int TmrWidth  = $clog2(MaxCycles + 1);

    localparam logic [TmrWidth-1:0] PulseLoad  = TmrWidth'(PulseCycles - 1);
    localparam logic [TmrWidth-1:0] SettleLoad =
        TmrWidth'((SettleCycles > 0) ? (SettleCycles - 1) : 0);
    localparam logic [TmrWidth-1:0] TmrZero    = {TmrWidth{1'b0}};
    localparam logic [TmrWidth-1:0] TmrOne     = TmrWidth'(1'b1);

    if (PulseCycles < 1) begin : g_pulse_chk
        $error("slv_guard_rst_ctrl: PulseCycles must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ASSERT = 2'b01,
        ST_SETTLE = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    state_e                 state_r;
    logic [TmrWidth-1:0]    tmr_r;
    logic                   sub_rst_n_r;
    logic                   rst_stat_r;
    logic                   busy_r;
    logic                   done_r;
    logic [RstCntWidth-1:0] rst_cnt_r;

    // Completed-sequence count holds at all-ones instead of wrapping.
    function automatic logic [RstCntWidth-1:0] sat_inc(input logic [RstCntWidth-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + RstCntWidth'(1'b1);
        end
    endfunction

    // Sequencer FSM; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            tmr_r       <= TmrZero;
            sub_rst_n_r <= 1'b1;
            rst_stat_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rst_cnt_r   <= {RstCntWidth{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rst_req_i && rst_en_i) begin
                        state_r     <= ST_ASSERT;
                        tmr_r       <= PulseLoad;
                        sub_rst_n_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (tmr_r != TmrZero) begin
                        tmr_r <= tmr_r - TmrOne;
                    end else if (SettleCycles > 0) begin
                        state_r     <= ST_SETTLE;
                        tmr_r       <= SettleLoad;
                        sub_rst_n_r <= 1'b1;
                    end else begin
                        state_r     <= ST_DONE;
                        sub_rst_n_r <= 1'b1;
                        rst_stat_r  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_r != TmrZero) begin
                        tmr_r <= tmr_r - TmrOne;
                    end else begin
                        state_r    <= ST_DONE;
                        rst_stat_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // The request may already be low here if it dropped mid-pulse.
                    if (!rst_req_i) begin
                        state_r    <= ST_IDLE;
                        rst_stat_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        rst_cnt_r  <= sat_inc(rst_cnt_r);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    tmr_r       <= TmrZero;
                    sub_rst_n_r <= 1'b1;
                    rst_stat_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign sub_rst_no = sub_rst_n_r;
    assign rst_stat_o = rst_stat_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign rst_cnt_o  = rst_cnt_r;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Scoreboard bench for slv_guard_rst_ctrl: two instances (settle / no-settle,
// wide / 2-bit counter) share stimulus and are checked against a timestamp model.
module tb_slv_guard_rst_ctrl;

    localparam int P_A = 16, S_A = 8, W_A = 8;
    localparam int P_B = 16, S_B = 0, W_B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic req = 1'b0;

    logic sub_a, stat_a, busy_a, done_a;
    logic [W_A-1:0] cnt_a;
    logic sub_b, stat_b, busy_b, done_b;
    logic [W_B-1:0] cnt_b;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    slv_guard_rst_ctrl #(.PulseCycles(P_A), .SettleCycles(S_A), .RstCntWidth(W_A)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .rst_en_i(en), .rst_req_i(req),
        .sub_rst_no(sub_a), .rst_stat_o(stat_a), .busy_o(busy_a), .done_o(done_a),
        .rst_cnt_o(cnt_a)
    );

    slv_guard_rst_ctrl #(.PulseCycles(P_B), .SettleCycles(S_B), .RstCntWidth(W_B)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .rst_en_i(en), .rst_req_i(req),
        .sub_rst_no(sub_b), .rst_stat_o(stat_b), .busy_o(busy_b), .done_o(done_b),
        .rst_cnt_o(cnt_b)
    );

    typedef struct packed {
        logic sub_n;
        logic stat;
        logic busy;
        logic done;
        int   cnt;
    } exp_t;

    localparam exp_t RST_EXP = '{sub_n: 1'b1, stat: 1'b0, busy: 1'b0, done: 1'b0, cnt: 0};

    exp_t exp_qa[$];
    exp_t exp_qb[$];

    // Reference model: a sequence is a start edge t; everything else is arithmetic on t.
    int  pp[2]   = '{P_A, P_B};
    int  ss[2]   = '{S_A, S_B};
    int  cmax[2] = '{(1 << W_A) - 1, (1 << W_B) - 1};
    bit  act[2]  = '{1'b0, 1'b0};
    int  tt[2]   = '{0, 0};
    int  mc[2]   = '{0, 0};

    function automatic exp_t model_edge(input int d);
        exp_t r;
        logic dn;
        if (!rst_n) begin
            act[d] = 1'b0;
            mc[d]  = 0;
            return RST_EXP;
        end
        dn = 1'b0;
        if (act[d]) begin
            if (edge_n >= tt[d] + pp[d] + ss[d] + 1 && !req) begin
                act[d] = 1'b0;
                dn     = 1'b1;
                if (mc[d] < cmax[d]) mc[d] = mc[d] + 1;
            end
        end else if (req && en) begin
            act[d] = 1'b1;
            tt[d]  = edge_n;
        end
        r.sub_n = !(act[d] && edge_n <= tt[d] + pp[d] - 1);
        r.stat  = act[d] && edge_n >= tt[d] + pp[d] + ss[d];
        r.busy  = act[d];
        r.done  = dn;
        r.cnt   = mc[d];
        return r;
    endfunction

    task automatic cmp(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, edge_n, got, want);
        end
    endtask

    // Monitor: compare every presented output cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_qa.size() > 0) begin
            e = exp_qa.pop_front();
            cmp("a.sub_rst_no", int'(sub_a), int'(e.sub_n));
            cmp("a.rst_stat_o", int'(stat_a), int'(e.stat));
            cmp("a.busy_o", int'(busy_a), int'(e.busy));
            cmp("a.done_o", int'(done_a), int'(e.done));
            cmp("a.rst_cnt_o", int'(cnt_a), e.cnt);
        end
        if (exp_qb.size() > 0) begin
            e = exp_qb.pop_front();
            cmp("b.sub_rst_no", int'(sub_b), int'(e.sub_n));
            cmp("b.rst_stat_o", int'(stat_b), int'(e.stat));
            cmp("b.busy_o", int'(busy_b), int'(e.busy));
            cmp("b.done_o", int'(done_b), int'(e.done));
            cmp("b.rst_cnt_o", int'(cnt_b), e.cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        edge_n++;
        exp_qa.push_back(model_edge(0));
        exp_qb.push_back(model_edge(1));
        #1;
    endtask

    // Async reset inside a cycle: the pending expectation becomes the reset state.
    task automatic async_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0;
            mc[d]  = 0;
        end
        if (exp_qa.size() > 0) void'(exp_qa.pop_back());
        if (exp_qb.size() > 0) void'(exp_qb.pop_back());
        exp_qa.push_back(RST_EXP);
        exp_qb.push_back(RST_EXP);
        #1;
        cmp("rst.a.sub_rst_no", int'(sub_a), 1);
        cmp("rst.a.busy_o", int'(busy_a), 0);
        cmp("rst.a.rst_cnt_o", int'(cnt_a), 0);
        cmp("rst.b.sub_rst_no", int'(sub_b), 1);
        cmp("rst.b.busy_o", int'(busy_b), 0);
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return stat_a;
            1:       return done_a;
            2:       return stat_b;
            3:       return done_b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int s, input int limit, output int n);
        n = 0;
        while (!sig(s) && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (!sig(s)) begin
            errors++;
            $display("FAIL wait_timeout sel=%0d after %0d cycles", s, n);
        end
    endtask

    initial begin
        int n;
        int nb;
        int sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};

        repeat (3) step();
        cmp("reset.a.sub_rst_no", int'(sub_a), 1);
        cmp("reset.a.rst_stat_o", int'(stat_a), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) step();

        // Basic sequence: both instances see the same request.
        req = 1'b1;
        wait_for(2, 100, nb);
        cmp("latency_settle0", nb, P_B + 1);
        wait_for(0, 100, n);
        cmp("latency_basic", nb + n, P_A + S_A + 1);
        step();
        req = 1'b0;
        wait_for(1, 10, n);
        cmp("done_after_drop", n, 1);
        cmp("count_after_basic", int'(cnt_a), 1);
        repeat (3) step();

        // Disabled: request held, nothing may start until enable returns.
        en  = 1'b0;
        req = 1'b1;
        repeat (100) step();
        cmp("disabled.busy_o", int'(busy_a), 0);
        cmp("disabled.sub_rst_no", int'(sub_a), 1);
        en = 1'b1;
        step();
        cmp("enable.busy_o", int'(busy_a), 1);
        cmp("enable.sub_rst_no", int'(sub_a), 0);
        req = 1'b0;
        wait_for(1, 100, n);
        repeat (2) step();

        // Early drop: one-cycle request still produces a full sequence.
        req = 1'b1;
        step();
        req = 1'b0;
        wait_for(1, 100, n);
        cmp("early_drop.cycles", n, P_A + S_A + 1);
        repeat (2) step();

        // Mid-sequence reset at t+5 with the request kept high.
        req = 1'b1;
        repeat (6) step();
        async_reset();
        repeat (2) step();
        rst_n = 1'b1;
        wait_for(0, 100, n);
        cmp("post_reset_latency", n, P_A + S_A + 1);
        req = 1'b0;
        wait_for(1, 10, n);
        repeat (2) step();

        // Saturation of the 2-bit counter after a fresh reset.
        async_reset();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req = 1'b1;
            wait_for(2, 100, n);
            req = 1'b0;
            wait_for(3, 10, n);
            cmp("saturation", int'(cnt_b), sat_exp[i]);
            repeat (2) step();
        end

        // Randomized phase with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) req = ~req;
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
